// File: rtl/nmos_phase_pkg.sv
// nmos_phase_pkg
// Shared definitions for the two-phase NMOS clock-enable sequencer.
//   - 3-bit state encodings and the enum built on them.
//   - timer_width(): width of the shared phase timer. It must hold the
//     largest reload value, which is max(PH1_LEN, PH2_LEN, GAP_LEN) - 1.
package nmos_phase_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PH1   = 3'd1;
    localparam logic [2:0] ST_GAP12 = 3'd2;
    localparam logic [2:0] ST_PH2   = 3'd3;
    localparam logic [2:0] ST_GAP21 = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        PH1   = ST_PH1,
        GAP12 = ST_GAP12,
        PH2   = ST_PH2,
        GAP21 = ST_GAP21
    } phase_state_t;

    // clog2 of the longest phase. It is never less than 1 bit, so that a
    // design where every phase has length 1 still gets a real register.
    function automatic int timer_width(input int ph1Len, input int ph2Len,
                                       input int gapLen);
        int longest;
        longest = ph1Len;
        if (ph2Len > longest) longest = ph2Len;
        if (gapLen > longest) longest = gapLen;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/nmos_phase_timer.sv
// nmos_phase_timer
// A loadable down-counter. One instance is shared by every timed state of
// the phase sequencer. It stops when it reaches zero.
// Ports:
//   i_clk    clock
//   i_rst    asynchronous active-high reset (the count clears to 0)
//   i_load   load i_value this cycle. Load takes priority over counting.
//   i_value  reload value (phase length - 1)
//   o_count  current count
//   o_zero   high when the count is 0
module nmos_phase_timer #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load on state entry, otherwise count down and stop at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/nmos_phase_gen.sv
// nmos_phase_gen
// Two-phase non-overlapping clock-enable sequencer. It supports free-run,
// a clean halt at the end of a cycle, and single-step operation.
// One machine cycle is the sequence PH1 -> GAP12 -> PH2 -> GAP21.
// Ports:
//   main_clk    the only clock
//   main_rst    asynchronous active-high reset
//   run         level input: free-run while high
//   step        pulse input: request one full cycle (ignored while run=1)
//   phi1/phi2   phase enables (drive C1/C2)
//   busy        high whenever the FSM is not idle
//   cycle_done  one-cycle pulse on the last cycle of each full cycle
//   step_ack    pulses with cycle_done when that cycle was a stepped one
//   cycle_cnt   completed-cycle count. Wraps silently.
module nmos_phase_gen
    import nmos_phase_pkg::*;
#(
    parameter int PH1_LEN = 2,
    parameter int PH2_LEN = 2,
    parameter int GAP_LEN = 1,
    parameter int CNT_W   = 32
) (
    input  logic             main_clk,
    input  logic             main_rst,
    input  logic             run,
    input  logic             step,
    output logic             phi1,
    output logic             phi2,
    output logic             busy,
    output logic             cycle_done,
    output logic             step_ack,
    output logic [CNT_W-1:0] cycle_cnt
);

    if (PH1_LEN < 1) begin : g_bad_ph1
        $error("PH1_LEN must be at least 1");
    end
    if (PH2_LEN < 1) begin : g_bad_ph2
        $error("PH2_LEN must be at least 1");
    end
    if (GAP_LEN < 1) begin : g_bad_gap
        $error("GAP_LEN must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    localparam int TW = timer_width(PH1_LEN, PH2_LEN, GAP_LEN);
    localparam logic [TW-1:0] PH1_LOAD = TW'(PH1_LEN - 1);
    localparam logic [TW-1:0] PH2_LOAD = TW'(PH2_LEN - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_LEN - 1);

    phase_state_t     r_state;
    phase_state_t     w_next_state;
    logic             w_load;
    logic [TW-1:0]    w_load_value;
    logic [TW-1:0]    w_count;
    logic             w_zero;
    logic             w_enter_ph1;
    logic             w_done_next;
    logic             r_step_pend;
    logic             r_stepped;
    logic             r_phi1;
    logic             r_phi2;
    logic             r_busy;
    logic             r_cycle_done;
    logic             r_step_ack;
    logic [CNT_W-1:0] r_cycle_cnt;

    nmos_phase_timer #(
        .W(TW)
    ) u_timer (
        .i_clk   (main_clk),
        .i_rst   (main_rst),
        .i_load  (w_load),
        .i_value (w_load_value),
        .o_count (w_count),
        .o_zero  (w_zero)
    );

    // Next-state logic. Every transition that enters a timed state also
    // reloads the shared timer with that state's length minus one.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_value = '0;
        case (r_state)
            IDLE: begin
                if (run || r_step_pend) begin
                    w_next_state = PH1;
                    w_load       = 1'b1;
                    w_load_value = PH1_LOAD;
                end
            end
            PH1: begin
                if (w_zero) begin
                    w_next_state = GAP12;
                    w_load       = 1'b1;
                    w_load_value = GAP_LOAD;
                end
            end
            GAP12: begin
                if (w_zero) begin
                    w_next_state = PH2;
                    w_load       = 1'b1;
                    w_load_value = PH2_LOAD;
                end
            end
            PH2: begin
                if (w_zero) begin
                    w_next_state = GAP21;
                    w_load       = 1'b1;
                    w_load_value = GAP_LOAD;
                end
            end
            GAP21: begin
                if (w_zero) begin
                    if (run || r_step_pend) begin
                        w_next_state = PH1;
                        w_load       = 1'b1;
                        w_load_value = PH1_LOAD;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The next cycle is the final cycle of GAP21 in one of two cases:
    // entering a 1-cycle gap from PH2, or counting the gap down from 1 to 0.
    assign w_done_next = ((r_state == PH2) && w_zero && (GAP_LEN == 1)) ||
                         ((r_state == GAP21) && (w_count == TW'(1)));

    assign w_enter_ph1 = (w_next_state == PH1) && (r_state != PH1);

    // State and registered outputs, all decoded from the next state.
    // r_stepped remembers whether the running cycle was started by a
    // queued step, so that step_ack can fire when that cycle completes.
    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            r_state      <= IDLE;
            r_step_pend  <= 1'b0;
            r_stepped    <= 1'b0;
            r_phi1       <= 1'b0;
            r_phi2       <= 1'b0;
            r_busy       <= 1'b0;
            r_cycle_done <= 1'b0;
            r_step_ack   <= 1'b0;
            r_cycle_cnt  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_phi1       <= (w_next_state == PH1);
            r_phi2       <= (w_next_state == PH2);
            r_busy       <= (w_next_state != IDLE);
            r_cycle_done <= w_done_next;
            r_step_ack   <= w_done_next && r_stepped;
            if (w_done_next) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_enter_ph1) begin
                r_stepped <= r_step_pend;
            end
            if (w_enter_ph1) begin
                r_step_pend <= 1'b0;
            end else if (step && !run) begin
                r_step_pend <= 1'b1;
            end
        end
    end

    assign phi1       = r_phi1;
    assign phi2       = r_phi2;
    assign busy       = r_busy;
    assign cycle_done = r_cycle_done;
    assign step_ack   = r_step_ack;
    assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_nmos_phase_gen.sv
// tb_nmos_phase_gen
// Directed bench for nmos_phase_gen. It uses three instances:
//   dut      default parameters (period 6)
//   dutW4    CNT_W=4, used to observe the counter wrapping
//   dutAlt   PH1_LEN=1, PH2_LEN=3, GAP_LEN=2 (period 8)
// Inputs change 1 time unit after a rising edge, and outputs are
// sampled at that same point.
module tb_nmos_phase_gen;

    logic        main_clk;
    logic        main_rst;
    logic        run;
    logic        step;
    logic        runW4;
    logic        runAlt;

    logic        phi1, phi2, busy, cycleDone, stepAck;
    logic [31:0] cycleCnt;
    logic        phi1W4, phi2W4, busyW4, cycleDoneW4, stepAckW4;
    logic [3:0]  cycleCntW4;
    logic        phi1Alt, phi2Alt, busyAlt, cycleDoneAlt, stepAckAlt;
    logic [31:0] cycleCntAlt;

    int compareCount;
    int mismatchCount;
    int ackCount;
    int busyCount;
    int k;

    nmos_phase_gen dut (
        .main_clk   (main_clk),
        .main_rst   (main_rst),
        .run        (run),
        .step       (step),
        .phi1       (phi1),
        .phi2       (phi2),
        .busy       (busy),
        .cycle_done (cycleDone),
        .step_ack   (stepAck),
        .cycle_cnt  (cycleCnt)
    );

    nmos_phase_gen #(.CNT_W(4)) dutW4 (
        .main_clk   (main_clk),
        .main_rst   (main_rst),
        .run        (runW4),
        .step       (1'b0),
        .phi1       (phi1W4),
        .phi2       (phi2W4),
        .busy       (busyW4),
        .cycle_done (cycleDoneW4),
        .step_ack   (stepAckW4),
        .cycle_cnt  (cycleCntW4)
    );

    nmos_phase_gen #(.PH1_LEN(1), .PH2_LEN(3), .GAP_LEN(2)) dutAlt (
        .main_clk   (main_clk),
        .main_rst   (main_rst),
        .run        (runAlt),
        .step       (1'b0),
        .phi1       (phi1Alt),
        .phi2       (phi2Alt),
        .busy       (busyAlt),
        .cycle_done (cycleDoneAlt),
        .step_ack   (stepAckAlt),
        .cycle_cnt  (cycleCntAlt)
    );

    // Free-running 10-unit clock.
    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic s,
                                 input logic rW4, input logic rAlt);
        run    = r;
        step   = s;
        runW4  = rW4;
        runAlt = rAlt;
    endtask

    task automatic applyReset();
        main_rst = 1'b1;
        tick();
        main_rst = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            mismatchCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // The whole directed sequence lives in this one block.
    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        main_rst      = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset values
        checkOutput("rst_phi1", 32'(phi1), 32'd0);
        checkOutput("rst_phi2", 32'(phi2), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(cycleDone), 32'd0);
        checkOutput("rst_ack", 32'(stepAck), 32'd0);
        checkOutput("rst_cnt", cycleCnt, 32'd0);
        main_rst = 1'b0;
        tick();
        checkOutput("idle_stays_idle", 32'(busy), 32'd0);

        // Free-run for 20 cycles: phi1 110000, phi2 000110, done on the 6th
        $display("[TB] free-run");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            k = (c - 1) % 6;
            checkOutput($sformatf("free_phi1_c%0d", c), 32'(phi1), 32'(k < 2));
            checkOutput($sformatf("free_phi2_c%0d", c), 32'(phi2), 32'(k == 3 || k == 4));
            checkOutput($sformatf("free_done_c%0d", c), 32'(cycleDone), 32'(k == 5));
            checkOutput($sformatf("free_overlap_c%0d", c), 32'(phi1 & phi2), 32'd0);
            checkOutput($sformatf("free_busy_c%0d", c), 32'(busy), 32'd1);
            checkOutput($sformatf("free_cnt_c%0d", c), cycleCnt, 32'(c / 6));
        end

        // run drops during PH1 of cycle 2: the cycle finishes, then the FSM idles
        $display("[TB] halt mid-cycle");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 7; c++) tick();
        checkOutput("halt_in_ph1", 32'(phi1), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("halt_c8_phi1", 32'(phi1), 32'd1);
        tick();
        tick();
        checkOutput("halt_c10_phi2", 32'(phi2), 32'd1);
        tick();
        tick();
        checkOutput("halt_c12_done", 32'(cycleDone), 32'd1);
        checkOutput("halt_c12_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("halt_c13_busy", 32'(busy), 32'd0);
        checkOutput("halt_cnt", cycleCnt, 32'd2);
        tick();
        tick();
        checkOutput("halt_c15_phi1", 32'(phi1), 32'd0);

        // A single step gives exactly one 6-cycle sequence, with the ack on its last cycle
        $display("[TB] single step");
        applyReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("step_pend_idle", 32'(busy), 32'd0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            k = c - 1;
            checkOutput($sformatf("step_phi1_c%0d", c), 32'(phi1), 32'(k < 2));
            checkOutput($sformatf("step_phi2_c%0d", c), 32'(phi2), 32'(k == 3 || k == 4));
            checkOutput($sformatf("step_done_c%0d", c), 32'(cycleDone), 32'(k == 5));
            checkOutput($sformatf("step_ack_c%0d", c), 32'(stepAck), 32'(k == 5));
        end
        tick();
        checkOutput("step_busy_after", 32'(busy), 32'd0);
        checkOutput("step_ack_after", 32'(stepAck), 32'd0);
        checkOutput("step_cnt", cycleCnt, 32'd1);

        // Three steps arrive during one stepped cycle: one is queued, so two cycles run back to back
        $display("[TB] queued steps");
        applyReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        ackCount  = 0;
        busyCount = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (busy) busyCount++;
            if (stepAck) ackCount++;
            if (c == 6 || c == 12) begin
                checkOutput($sformatf("queue_ack_c%0d", c), 32'(stepAck), 32'd1);
            end
            if (c == 7) begin
                checkOutput("queue_b2b_phi1", 32'(phi1), 32'd1);
            end
            applyStimulus(1'b0, (c == 1 || c == 3 || c == 4), 1'b0, 1'b0);
        end
        checkOutput("queue_busy_cycles", 32'(busyCount), 32'd12);
        checkOutput("queue_ack_count", 32'(ackCount), 32'd2);
        checkOutput("queue_cnt", cycleCnt, 32'd2);
        checkOutput("queue_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of PH2
        $display("[TB] async reset mid-PH2");
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 10; c++) tick();
        checkOutput("arst_pre_phi2", 32'(phi2), 32'd1);
        checkOutput("arst_pre_cnt", cycleCnt, 32'd1);
        #2;
        main_rst = 1'b1;
        #1;
        checkOutput("arst_phi2", 32'(phi2), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_cnt", cycleCnt, 32'd0);
        tick();
        main_rst = 1'b0;
        tick();
        checkOutput("arst_restart_phi1", 32'(phi1), 32'd1);
        checkOutput("arst_restart_phi2", 32'(phi2), 32'd0);

        // A 4-bit counter wraps after 16 cycles; the alternate timing has period 8
        $display("[TB] counter wrap and alternate timing");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int c = 1; c <= 97; c++) begin
            tick();
            if (c <= 16) begin
                k = (c - 1) % 8;
                checkOutput($sformatf("alt_phi1_c%0d", c), 32'(phi1Alt), 32'(k == 0));
                checkOutput($sformatf("alt_phi2_c%0d", c), 32'(phi2Alt), 32'(k >= 3 && k <= 5));
                checkOutput($sformatf("alt_done_c%0d", c), 32'(cycleDoneAlt), 32'(k == 7));
            end
            if (c == 16) checkOutput("alt_cnt", cycleCntAlt, 32'd2);
            if (c == 90) checkOutput("w4_cnt_15", 32'(cycleCntW4), 32'd15);
            if (c == 96) begin
                checkOutput("w4_cnt_wrap", 32'(cycleCntW4), 32'd0);
                checkOutput("w4_done_wrap", 32'(cycleDoneW4), 32'd1);
            end
            if (c == 97) begin
                checkOutput("w4_phi1_after", 32'(phi1W4), 32'd1);
                checkOutput("w4_busy_after", 32'(busyW4), 32'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
